// File: rtl/gmii_rx_sink.sv
// gmii_rx_sink: GMII/MII receiver that strips preamble and FCS, checks CRC-32 and streams the payload
module gmii_rx_sink #(
  parameter int DATA_WIDTH    = 8,
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] gmii_d,
  input  logic                  gmii_en,
  input  logic                  gmii_er,
  input  logic                  gmii_clk_en,
  input  logic                  gmii_mii_sel,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [CNT_WIDTH-1:0]  frames_ok,
  output logic [CNT_WIDTH-1:0]  frames_bad
);
  localparam int LW = $clog2(MAX_FRAME_LEN + 2);
  typedef enum logic [2:0] {S_WAIT_IDLE, S_IDLE, S_PRE, S_PAY, S_DROP} state_t;
  state_t          r_state, w_state_nxt;
  logic            r_mii, r_half, r_er;
  logic [3:0]      r_nib;
  logic [31:0]     r_crc, w_crc;
  logic [LW-1:0]   r_len;
  logic [3:0][7:0] r_dly;
  logic [7:0]      r_hold, w_byte;
  logic            w_mii, w_acc, w_end, w_sfd, w_over, w_held, w_err;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction
  // Byte assembly, frame-position and end-of-frame error decode
  always_comb begin
    w_mii  = (r_state == S_IDLE || r_state == S_WAIT_IDLE) ? gmii_mii_sel : r_mii;
    w_acc  = gmii_clk_en & gmii_en & (~w_mii | r_half);
    w_end  = gmii_clk_en & ~gmii_en;
    w_byte = w_mii ? {gmii_d[3:0], r_nib} : gmii_d[7:0];
    w_crc  = crc_byte(r_crc, w_byte);
    w_sfd  = (r_state == S_PRE) && w_acc && (w_byte == 8'hD5);
    w_over = (r_state == S_PAY) && w_acc && (r_len == LW'(MAX_FRAME_LEN));
    w_held = r_len >= LW'(5);
    w_err  = r_er | (r_crc != 32'hDEBB20E3) | (r_len < LW'(MIN_FRAME_LEN)) | (r_mii & r_half);
  end
  // Next-state decode of the frame tracker
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_IDLE: w_state_nxt = w_end ? S_IDLE : S_WAIT_IDLE;
      S_IDLE:      w_state_nxt = !w_acc ? S_IDLE : (w_byte == 8'h55) ? S_PRE : S_DROP;
      S_PRE:       w_state_nxt = w_end ? S_IDLE : !w_acc ? S_PRE : (w_byte == 8'h55) ? S_PRE :
                                 (w_byte == 8'hD5) ? S_PAY : S_DROP;
      S_PAY:       w_state_nxt = w_end ? S_IDLE : w_over ? S_DROP : S_PAY;
      S_DROP:      w_state_nxt = w_end ? S_IDLE : S_DROP;
      default:     w_state_nxt = S_WAIT_IDLE;
    endcase
  end
  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_WAIT_IDLE;
    else      r_state <= w_state_nxt;
  end
  // Nibble pairing, CRC, FCS delay line, beat generation and counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mii         <= 1'b0;
      r_half        <= 1'b0;
      r_nib         <= '0;
      r_er          <= 1'b0;
      r_crc         <= 32'hFFFFFFFF;
      r_len         <= '0;
      r_dly         <= '0;
      r_hold        <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      frames_ok     <= '0;
      frames_bad    <= '0;
    end else begin
      r_mii         <= w_mii;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      if (gmii_clk_en) r_half <= gmii_en & w_mii & ~r_half;
      if (gmii_clk_en & gmii_en & w_mii & ~r_half) r_nib <= gmii_d[3:0];
      if (w_sfd) begin
        r_crc <= 32'hFFFFFFFF;
        r_len <= '0;
        r_er  <= 1'b0;
      end
      if (r_state == S_PAY) begin
        if (gmii_clk_en & gmii_en & gmii_er) r_er <= 1'b1;
        if (w_end) begin
          m_axis_tvalid <= w_held;
          m_axis_tlast  <= w_held;
          m_axis_tuser  <= w_held & w_err;
          m_axis_tdata  <= w_held ? r_hold : m_axis_tdata;
          frames_ok     <= frames_ok + CNT_WIDTH'(!w_err);
          frames_bad    <= frames_bad + CNT_WIDTH'(w_err);
        end else if (w_acc) begin
          r_crc         <= w_crc;
          r_len         <= r_len + LW'(1);
          r_dly         <= {r_dly[2:0], w_byte};
          r_hold        <= r_dly[3];
          m_axis_tvalid <= w_held;
          m_axis_tlast  <= w_over;
          m_axis_tuser  <= w_over;
          m_axis_tdata  <= w_held ? r_hold : m_axis_tdata;
          frames_bad    <= frames_bad + CNT_WIDTH'(w_over);
        end
      end
    end
  end
endmodule

// File: tb/tb_gmii_rx_sink.sv
// tb_gmii_rx_sink: directed frames in GMII and MII mode with checks on beats, tlast/tuser and counters
module tb_gmii_rx_sink;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  gmii_d = '0;
  logic        gmii_en = 1'b0, gmii_er = 1'b0, gmii_clk_en = 1'b0, gmii_mii_sel = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic [31:0] frames_ok, frames_bad;
  int          tests = 0, fails = 0, base = 0, ce_div = 1;
  logic [7:0]  fr[$];
  logic [7:0]  cap_d[$];
  logic        cap_l[$], cap_u[$];

  gmii_rx_sink dut (
    .clk(clk), .rst(rst), .gmii_d(gmii_d), .gmii_en(gmii_en), .gmii_er(gmii_er),
    .gmii_clk_en(gmii_clk_en), .gmii_mii_sel(gmii_mii_sel),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .frames_ok(frames_ok), .frames_bad(frames_bad)
  );

  always #5 clk = ~clk;

  // Record every output beat away from the active edge
  always @(negedge clk) begin
    if (m_axis_tvalid === 1'b1) begin
      cap_d.push_back(m_axis_tdata);
      cap_l.push_back(m_axis_tlast);
      cap_u.push_back(m_axis_tuser);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] x;
    x = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  task automatic build(input int n);
    logic [31:0] c;
    fr.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      fr.push_back(8'(i));
      c = crc_upd(c, 8'(i));
    end
    c = ~c;
    for (int i = 0; i < 4; i++) fr.push_back(8'(c >> (8 * i)));
  endtask

  task automatic put(input logic en, input logic [7:0] d, input logic er);
    for (int i = 1; i < ce_div; i++) begin
      gmii_clk_en = 1'b0;
      @(posedge clk); #1;
    end
    gmii_clk_en = 1'b1; gmii_en = en; gmii_d = d; gmii_er = er;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic er);
    if (gmii_mii_sel) begin
      put(1'b1, {4'h0, b[3:0]}, er);
      put(1'b1, {4'h0, b[7:4]}, er);
    end else put(1'b1, b, er);
  endtask

  task automatic idle(input int n);
    repeat (n) put(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_frame(input int er_at, input int rst_at, input bit odd_nib);
    repeat (7) send_byte(8'h55, 1'b0);
    send_byte(8'hD5, 1'b0);
    for (int i = 0; i < fr.size(); i++) begin
      if (i == rst_at) rst = 1'b0;
      send_byte(fr[i], i == er_at);
      if (i == rst_at) begin
        rst = 1'b1;
        base = cap_d.size();
      end
    end
    if (odd_nib) put(1'b1, 8'h00, 1'b0);
    idle(3);
  endtask

  task automatic check_frame(input string tag, input int exp_beats, input logic exp_user,
                             input int exp_ok, input int exp_bad);
    int n, mism, nl;
    n = cap_d.size() - base;
    mism = 0;
    nl = 0;
    for (int i = base; i < cap_d.size(); i++) begin
      if (cap_d[i] !== 8'(i - base)) mism++;
      if (cap_l[i] === 1'b1) nl++;
    end
    chk({tag, "_beats"}, 32'(n), 32'(exp_beats));
    chk({tag, "_data_mism"}, 32'(mism), 32'd0);
    if (exp_beats > 0) begin
      chk({tag, "_tlast_cnt"}, 32'(nl), 32'd1);
      chk({tag, "_tlast_pos"}, 32'(cap_l[$]), 32'd1);
      chk({tag, "_tuser"}, 32'(cap_u[$]), 32'(exp_user));
    end
    chk({tag, "_frames_ok"}, frames_ok, 32'(exp_ok));
    chk({tag, "_frames_bad"}, frames_bad, 32'(exp_bad));
    base = cap_d.size();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_tuser", 32'(m_axis_tuser), 32'd0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_ok", frames_ok, 32'd0);
    chk("rst_bad", frames_bad, 32'd0);
    rst = 1'b1;
    idle(3);

    build(60);
    send_frame(-1, -1, 0);
    check_frame("gmii_good", 60, 1'b0, 1, 0);

    build(60);
    fr[63] = fr[63] ^ 8'h01;
    send_frame(-1, -1, 0);
    check_frame("bad_fcs", 60, 1'b1, 1, 1);

    gmii_mii_sel = 1'b1;
    ce_div = 10;
    idle(2);
    build(60);
    send_frame(-1, -1, 0);
    check_frame("mii_good", 60, 1'b0, 2, 1);

    send_frame(-1, -1, 1);
    check_frame("mii_odd_nib", 60, 1'b1, 2, 2);

    gmii_mii_sel = 1'b0;
    ce_div = 1;
    idle(2);
    send_frame(20, -1, 0);
    check_frame("gmii_er", 60, 1'b1, 2, 3);

    build(16);
    send_frame(-1, -1, 0);
    check_frame("runt20", 16, 1'b1, 2, 4);

    build(0);
    send_frame(-1, -1, 0);
    check_frame("len4", 0, 1'b0, 2, 5);

    build(60);
    send_byte(8'h55, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    for (int i = 0; i < fr.size(); i++) send_byte(fr[i], 1'b0);
    idle(3);
    check_frame("bad_pre", 0, 1'b0, 2, 5);
    send_frame(-1, -1, 0);
    check_frame("after_bad_pre", 60, 1'b0, 3, 5);

    build(1516);
    send_frame(-1, -1, 0);
    check_frame("oversize", 1514, 1'b1, 3, 6);

    build(60);
    send_frame(-1, 30, 0);
    check_frame("mid_rst", 0, 1'b0, 0, 0);
    send_frame(-1, -1, 0);
    check_frame("after_rst", 60, 1'b0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
